mul_share_arbiter: RTL and testbench

Round-robin scheduler that shares a single unsigned multiplier (the 32x32 shift-and-add unit, registered output) among NREQ requesters. Accepts one operand pair at a time over a valid/ready handshake, drives the multiplier, waits the multiplier latency, and returns the full-width product to the granted requester over a second valid/ready handshake. Sits between the requester blocks and the multiplier instance; one operation in flight.

---
 rtl/mul_share_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/mul_share_arbiter.sv | 118 +++++++++++
 tb/tb_mul_share_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Imported by the round-robin arbiter and the top-level scheduler.
package mul_share_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MUL_LAT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for n items, never less than one bit so registers stay legal.
  function automatic int idx_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// searching upward and wrapping back to zero.
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_bits(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search; a path that skips an
    // assignment would otherwise infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // Walk from the farthest candidate back to ptr so the closest one wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one external unsigned multiplier among NREQ requesters, one operation
// in flight, with round-robin accept and a per-requester result handshake.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_result,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_result,
  output logic                  busy,
  output logic [31:0]           op_count
);

  localparam int IW = idx_bits(NREQ);
  localparam int CW = idx_bits(MUL_LAT);

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, gnt;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            accept, consume;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake strobes are held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    consume   = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          req_ready = arb_grant;
          if (arb_any) begin
            accept    = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) state_nxt = DONE;
        end
        DONE: begin
          rsp_valid[gnt] = 1'b1;
          if (rsp_ready[gnt]) begin
            consume   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      gnt        <= '0;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_result <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        mul_a <= req_a[arb_idx*WIDTH +: WIDTH];
        mul_b <= req_b[arb_idx*WIDTH +: WIDTH];
        gnt   <= arb_idx;
        cnt   <= CW'(MUL_LAT - 1);
        ptr   <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
      end
      // Operands stay put through BUSY so the multiplier output settles.
      if (state == BUSY) begin
        if (cnt == '0) rsp_result <= mul_result;
        else           cnt        <= cnt - CW'(1);
      end
      if (consume) op_count <= op_count + 32'd1;
    end
  end

  a_req_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_no_ready_busy : assert property (@(posedge clk) disable iff (rst) busy |-> (req_ready == '0));

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: accepts push expected products,
// an independent monitor pops and compares on every consumed response.
module tb_mul_share_arbiter;
  import mul_share_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  typedef struct {
    int          idx;
    logic [63:0] prod;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [2*WIDTH-1:0]    rsp_result;
  logic [WIDTH-1:0]      mul_a, mul_b;
  logic [2*WIDTH-1:0]    mul_result;
  logic                  busy;
  logic [31:0]           op_count;

  always #5 clk = ~clk;

  // Multiplier stand-in: product settles before the capture edge MUL_LAT edges
  // after the operand registers change.
  assign mul_result = 64'(mul_a) * 64'(mul_b);

  mul_share_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .MUL_LAT (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .busy       (busy),
    .op_count   (op_count)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  exp_t        exp_q[$];
  int          order_q[$];
  int          rsp_cyc_q[$];
  logic [63:0] exp_tbl[NREQ];
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // Monitor: a response is consumed at the next edge when valid meets ready.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(i), 64'hFFFF);
          end else begin
            mon_e = exp_q.pop_front();
            check("rsp_idx", 64'(i), 64'(mon_e.idx));
            check("rsp_result", rsp_result, mon_e.prod);
          end
          rsp_cyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic raise(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] p);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    exp_tbl[i]   = p;
    req_valid[i] = 1'b1;
  endtask

  // One clock: log accepts seen before the edge, drop their valid after it.
  task automatic step();
    logic [NREQ-1:0] acc;
    exp_t            e;
    @(negedge clk);
    acc = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        e.idx  = i;
        e.prod = exp_tbl[i];
        exp_q.push_back(e);
        order_q.push_back(i);
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic wait_rsp(input string name, input int target);
    int n;
    n = 0;
    while (rsp_cyc_q.size() < target && n < 30) begin
      step();
      n++;
    end
    check(name, 64'(rsp_cyc_q.size() >= target), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_o, base_r, n;
    bit rearmed;
    int want_order[5];
    want_order = '{0, 1, 2, 3, 0};

    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);

    // Single request, cycle by cycle.
    rst = 1'b0;
    raise(0, 32'd7, 32'd9, 64'd63);
    #1;
    check("single_req_ready", 64'(req_ready), 64'b0001);
    step();
    check("single_busy", 64'(busy), 64'd1);
    check("single_ready_low", 64'(req_ready), 64'd0);
    check("single_no_rsp_yet", 64'(rsp_valid), 64'd0);
    check("single_mul_a", 64'(mul_a), 64'd7);
    check("single_mul_b", 64'(mul_b), 64'd9);
    step();
    check("single_rsp_valid", 64'(rsp_valid), 64'b0001);
    check("single_rsp_result", rsp_result, 64'd63);
    step();
    check("single_rsp_drop", 64'(rsp_valid), 64'd0);
    check("single_idle", 64'(busy), 64'd0);
    check("single_op_count", 64'(op_count), 64'd1);

    // Full-width operands on requester 2.
    raise(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_rsp("full_done", rsp_cyc_q.size() + 1);
    check("full_op_count", 64'(op_count), 64'd2);

    // Contention from reset: all four request, requester 0 re-requests once.
    rst = 1'b1;
    raise(0, 32'd3, 32'd5, 64'd15);
    raise(1, 32'd100, 32'd200, 64'd20000);
    raise(2, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    raise(3, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    base_o  = order_q.size();
    base_r  = rsp_cyc_q.size();
    rearmed = 1'b0;
    n       = 0;
    while ((order_q.size() < base_o + 5 || rsp_cyc_q.size() < base_r + 5) && n < 40) begin
      step();
      n++;
      if (!rearmed && order_q.size() > base_o) begin
        raise(0, 32'd12, 32'd12, 64'd144);
        rearmed = 1'b1;
      end
    end
    check("cont_done", 64'(rsp_cyc_q.size() >= base_r + 5), 64'd1);
    for (int k = 0; k < 5; k++)
      check($sformatf("cont_order%0d", k), 64'(order_q[base_o+k]), 64'(want_order[k]));
    for (int k = 1; k < 5; k++)
      check($sformatf("cont_gap%0d", k),
            64'(rsp_cyc_q[base_r+k] - rsp_cyc_q[base_r+k-1]), 64'd3);
    check("cont_op_count", 64'(op_count), 64'd5);

    // Backpressure on requester 1 while requester 0 waits.
    rsp_ready = 4'b1101;
    raise(1, 32'd6, 32'd7, 64'd42);
    step();
    check("bp_grant", 64'(order_q[order_q.size()-1]), 64'd1);
    raise(0, 32'd2, 32'd3, 64'd6);
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
      check("bp_rsp_result", rsp_result, 64'd42);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    check("bp_mul_a_held", 64'(mul_a), 64'd6);
    rsp_ready = 4'b1111;
    step();
    check("bp_release_idle", 64'(busy), 64'd0);
    check("bp_release_rsp", 64'(rsp_valid), 64'd0);
    check("bp_next_ready", 64'(req_ready), 64'b0001);
    wait_rsp("bp_follow_done", base_r + 7);
    check("bp_op_count", 64'(op_count), 64'd7);

    // Reset while BUSY drops the operation and rewinds the pointer.
    raise(2, 32'd5, 32'd5, 64'd25);
    step();
    check("rmid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("rmid_busy_clr", 64'(busy), 64'd0);
    check("rmid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rmid_rsp_result", rsp_result, 64'd0);
    check("rmid_mul_a", 64'(mul_a), 64'd0);
    check("rmid_mul_b", 64'(mul_b), 64'd0);
    check("rmid_op_count", 64'(op_count), 64'd0);
    check("rmid_req_ready", 64'(req_ready), 64'd0);
    base_r = rsp_cyc_q.size();
    repeat (3) step();
    check("rmid_no_rsp", 64'(rsp_cyc_q.size()), 64'(base_r));
    base_o = order_q.size();
    raise(3, 32'd11, 32'd13, 64'd143);
    raise(1, 32'd4, 32'd5, 64'd20);
    wait_rsp("rmid_after_done", base_r + 2);
    check("rmid_ptr_zero", 64'(order_q[base_o]), 64'd1);
    check("rmid_second", 64'(order_q[base_o+1]), 64'd3);
    check("rmid_after_count", 64'(op_count), 64'd2);

    // Counter wrap from a preloaded all-ones value.
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    raise(0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    wait_rsp("wrap_done", rsp_cyc_q.size() + 1);
    check("wrap_op_count", 64'(op_count), 64'd0);

    repeat (2) step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
